// File: rtl/serial_subtractor_18_pkg.sv
// Shared constants and state encoding for the serial subtractor.
// Package name is sub_pkg; all serial_subtractor_18 files import it.
package sub_pkg;

    localparam int WIDTH_DEF = 18;
    localparam int SLICE_DEF = 2;
    localparam int NSLICE    = WIDTH_DEF / SLICE_DEF;
    localparam int CNT_W     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/serial_subtractor_18_if.sv
// Operand/result bundle for serial_subtractor_18.
// Optional zero/neg/ovf flag signals exist only when SUB_FLAGS_EN is defined.
interface serial_subtractor_18_if
    import sub_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
);

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;
`ifdef SUB_FLAGS_EN
    logic             zero;
    logic             neg;
    logic             ovf;

    modport master (
        output start, a, b,
        input  busy, done, diff, borrow_out, zero, neg, ovf
    );

    modport slave (
        input  start, a, b,
        output busy, done, diff, borrow_out, zero, neg, ovf
    );
`else
    modport master (
        output start, a, b,
        input  busy, done, diff, borrow_out
    );

    modport slave (
        input  start, a, b,
        output busy, done, diff, borrow_out
    );
`endif

endinterface

// File: rtl/serial_subtractor_18_slice.sv
// Two-bit subtract-with-borrow cell: {bout, d} = a - b - bin.
module sub_slice_2 (
    input  logic [1:0] a,
    input  logic [1:0] b,
    input  logic       bin,
    output logic [1:0] d,
    output logic       bout
);

    logic [2:0] res;

    // Result lies in -4..3, so bit 2 of the 3-bit difference is the borrow.
    assign res  = {1'b0, a} - {1'b0, b} - {2'b00, bin};
    assign d    = res[1:0];
    assign bout = res[2];

endmodule

// File: rtl/serial_subtractor_18.sv
// Bit-serial (2 bits/cycle) unsigned subtractor, diff = a - b mod 2^WIDTH.
// Define SUB_FLAGS_EN to add registered zero/neg/ovf result flags.
module serial_subtractor_18
    import sub_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int SLICE = SLICE_DEF
) (
    input logic                  clk,
    input logic                  rst,
    serial_subtractor_18_if.slave s
);

    localparam int             NS   = WIDTH / SLICE;
    localparam int             CW   = (NS > 1) ? $clog2(NS) : 1;
    localparam logic [CW-1:0]  LAST = CW'(NS - 1);

    state_t           state;
    state_t           state_nxt;
    logic             accept;
    logic             last;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] diff_q;
    logic [WIDTH-1:0] diff_nxt;
    logic             borrow_q;
    logic             borrow_out_q;
    logic             done_q;
    logic [SLICE-1:0] a_sl;
    logic [SLICE-1:0] b_sl;
    logic [SLICE-1:0] d_sl;
    logic             bout;
`ifdef SUB_FLAGS_EN
    logic             zero_q;
    logic             neg_q;
    logic             ovf_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        last      = 1'b0;
        case (state)
            IDLE: begin
                if (s.start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (cnt == LAST) begin
                    last      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Counter-selected slice feeds the single shared subtract cell.
    assign a_sl = a_q[int'(cnt) * SLICE +: SLICE];
    assign b_sl = b_q[int'(cnt) * SLICE +: SLICE];

    sub_slice_2 u_slice (
        .a    (a_sl),
        .b    (b_sl),
        .bin  (borrow_q),
        .d    (d_sl),
        .bout (bout)
    );

    always_comb begin
        diff_nxt = diff_q;
        diff_nxt[int'(cnt) * SLICE +: SLICE] = d_sl;
    end

    // Operand latch carries no reset; it is only read while RUN.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_q <= s.a;
            b_q <= s.b;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt          <= '0;
            diff_q       <= '0;
            borrow_q     <= 1'b0;
            borrow_out_q <= 1'b0;
            done_q       <= 1'b0;
`ifdef SUB_FLAGS_EN
            zero_q       <= 1'b0;
            neg_q        <= 1'b0;
            ovf_q        <= 1'b0;
`endif
        end else begin
            done_q <= last;
            if (accept) begin
                cnt      <= '0;
                diff_q   <= '0;
                borrow_q <= 1'b0;
            end else if (state == RUN) begin
                cnt      <= cnt + 1'b1;
                diff_q   <= diff_nxt;
                borrow_q <= bout;
                if (last) begin
                    borrow_out_q <= bout;
`ifdef SUB_FLAGS_EN
                    zero_q <= (diff_nxt == '0);
                    neg_q  <= diff_nxt[WIDTH-1];
                    ovf_q  <= (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                              (diff_nxt[WIDTH-1] != a_q[WIDTH-1]);
`endif
                end
            end
        end
    end

    assign s.busy       = (state == RUN);
    assign s.done       = done_q;
    assign s.diff       = diff_q;
    assign s.borrow_out = borrow_out_q;
`ifdef SUB_FLAGS_EN
    assign s.zero       = zero_q;
    assign s.neg        = neg_q;
    assign s.ovf        = ovf_q;
`endif

endmodule
